// File: rtl/xm_mem_responder.sv
// xm_mem_responder: multi-cycle memory responder with byte-lane RAM for the xmakina core port
module xm_mem_responder #(
  parameter int WORD        = 16,
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 2,
  parameter     INIT_FILE   = ""
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic            memEn_i,
  input  logic            memRW_i,
  input  logic            byteOp_i,
  input  logic [WORD-1:0] adr_i,
  input  logic [WORD-1:0] wrData_i,
  output logic [WORD-1:0] rdData_o,
  output logic            memBusy_o,
  output logic            memWr_o,
  output logic            misalign_o
);
  localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rw_q, rw_d, byte_q, byte_d;
  logic [ADDR_BITS:0] adr_q, adr_d;
  logic [WORD-1:0] wdata_q, wdata_d, rd_data_q, rd_data_d;
  logic mem_wr_q, mem_wr_d, mis_q, mis_d;
  logic [WORD-1:0] mem [2**ADDR_BITS];
  logic accept, commit, c_rw, c_byte;
  logic [ADDR_BITS:0] c_adr;
  logic [WORD-1:0] c_wdata, rd_word, wr_word;
  logic [ADDR_BITS-1:0] idx;
  logic [1:0] lane_we;
  logic unused_adr;
  assign unused_adr = ^adr_i[WORD-1:ADDR_BITS+1];
  always_comb begin
    accept    = memEn_i && state_q != BUSY;
    c_rw      = WAIT_CYCLES == 0 ? memRW_i : rw_q;
    c_byte    = WAIT_CYCLES == 0 ? byteOp_i : byte_q;
    c_adr     = WAIT_CYCLES == 0 ? adr_i[ADDR_BITS:0] : adr_q;
    c_wdata   = WAIT_CYCLES == 0 ? wrData_i : wdata_q;
    commit    = WAIT_CYCLES == 0 ? accept : (state_q == BUSY && cnt_q == '0);
    idx       = c_adr[ADDR_BITS:1];
    rd_word   = mem[idx];
    wr_word   = c_byte ? {2{c_wdata[7:0]}} : c_wdata;
    lane_we   = (!commit || !c_rw || arst_i) ? 2'b00 : !c_byte ? 2'b11 : c_adr[0] ? 2'b10 : 2'b01;
    rw_d      = accept ? memRW_i : rw_q;
    byte_d    = accept ? byteOp_i : byte_q;
    adr_d     = accept ? adr_i[ADDR_BITS:0] : adr_q;
    wdata_d   = accept ? wrData_i : wdata_q;
    state_d   = accept ? (WAIT_CYCLES == 0 ? DONE : BUSY) :
                state_q == BUSY ? (cnt_q == '0 ? DONE : BUSY) : IDLE;
    cnt_d     = accept ? CNT_LOAD : (state_q == BUSY && cnt_q != '0) ? cnt_q - 1'b1 : '0;
    mem_wr_d  = commit && !c_rw;
    mis_d     = commit && !c_byte && c_adr[0];
    rd_data_d = !mem_wr_d ? rd_data_q :
                !c_byte ? rd_word :
                {{(WORD-8){1'b0}}, c_adr[0] ? rd_word[WORD-1:WORD-8] : rd_word[7:0]};
  end
  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rw_q      <= 1'b0;
      byte_q    <= 1'b0;
      adr_q     <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      mem_wr_q  <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rw_q      <= rw_d;
      byte_q    <= byte_d;
      adr_q     <= adr_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
      mem_wr_q  <= mem_wr_d;
      mis_q     <= mis_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (lane_we[0]) mem[idx][7:0] <= wr_word[7:0];
    if (lane_we[1]) mem[idx][WORD-1:8] <= wr_word[WORD-1:8];
  end
  assign rdData_o   = rd_data_q;
  assign memBusy_o  = state_q == BUSY;
  assign memWr_o    = mem_wr_q;
  assign misalign_o = mis_q;
endmodule

// File: tb/tb_xm_mem_responder.sv
// tb_xm_mem_responder: directed checks of a 2-wait-state and a zero-wait-state responder
module tb_xm_mem_responder;
  logic clk = 1'b0, rst;
  logic en, rw, byt, en0, rw0, byt0;
  logic [15:0] adr, wd, adr0, wd0;
  logic [15:0] rd, rd0;
  logic busy, wr, mis, busy0, wr0, mis0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  xm_mem_responder #(.WORD(16), .ADDR_BITS(10), .WAIT_CYCLES(2)) u2 (
    .clk_i(clk), .arst_i(rst), .memEn_i(en), .memRW_i(rw), .byteOp_i(byt),
    .adr_i(adr), .wrData_i(wd), .rdData_o(rd), .memBusy_o(busy), .memWr_o(wr),
    .misalign_o(mis));
  xm_mem_responder #(.WORD(16), .ADDR_BITS(10), .WAIT_CYCLES(0)) u0 (
    .clk_i(clk), .arst_i(rst), .memEn_i(en0), .memRW_i(rw0), .byteOp_i(byt0),
    .adr_i(adr0), .wrData_i(wd0), .rdData_o(rd0), .memBusy_o(busy0), .memWr_o(wr0),
    .misalign_o(mis0));
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // One full transaction on the 2-wait responder, checking busy, strobe, misalign and read data.
  task automatic req2(input logic r_w, input logic b, input logic [15:0] a, input logic [15:0] d,
                      input logic [15:0] exp_rd, input logic exp_mis, input string tag);
    @(negedge clk); en = 1'b1; rw = r_w; byt = b; adr = a; wd = d;
    @(negedge clk); en = 1'b0;
    chk({tag, "/busy1"}, {15'd0, busy}, 16'd1);
    chk({tag, "/wr1"}, {15'd0, wr}, 16'd0);
    @(negedge clk);
    chk({tag, "/busy2"}, {15'd0, busy}, 16'd1);
    @(negedge clk);
    chk({tag, "/busy_done"}, {15'd0, busy}, 16'd0);
    chk({tag, "/wr_done"}, {15'd0, wr}, {15'd0, ~r_w});
    chk({tag, "/mis_done"}, {15'd0, mis}, {15'd0, exp_mis});
    chk({tag, "/rd"}, rd, exp_rd);
    @(negedge clk);
    chk({tag, "/wr_after"}, {15'd0, wr}, 16'd0);
    chk({tag, "/mis_after"}, {15'd0, mis}, 16'd0);
  endtask
  initial begin
    rst = 1'b1; en = 1'b0; rw = 1'b0; byt = 1'b0; adr = '0; wd = '0;
    en0 = 1'b0; rw0 = 1'b0; byt0 = 1'b0; adr0 = '0; wd0 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst/busy", {15'd0, busy}, 16'd0);
    chk("rst/wr", {15'd0, wr}, 16'd0);
    chk("rst/mis", {15'd0, mis}, 16'd0);
    chk("rst/rd", rd, 16'h0000);
    chk("rst/rd0", rd0, 16'h0000);
    req2(1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, "t1w");
    req2(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, "t1r");
    req2(1'b1, 1'b1, 16'h0011, 16'h0012, 16'hBEEF, 1'b0, "t2bw");
    req2(1'b0, 1'b0, 16'h0010, 16'h0000, 16'h12EF, 1'b0, "t2wr");
    req2(1'b0, 1'b1, 16'h0010, 16'h0000, 16'h00EF, 1'b0, "t2b0");
    req2(1'b0, 1'b1, 16'h0011, 16'h0000, 16'h0012, 1'b0, "t2b1");
    // Zero-wait responder: three writes then three reads on consecutive edges.
    @(negedge clk); en0 = 1'b1; rw0 = 1'b1; adr0 = 16'h0000; wd0 = 16'h1111;
    @(negedge clk); adr0 = 16'h0002; wd0 = 16'h2222;
    chk("t3/wbusy", {15'd0, busy0}, 16'd0);
    chk("t3/wwr", {15'd0, wr0}, 16'd0);
    @(negedge clk); adr0 = 16'h0004; wd0 = 16'h3333;
    @(negedge clk); rw0 = 1'b0; adr0 = 16'h0000;
    chk("t3/wwr3", {15'd0, wr0}, 16'd0);
    @(negedge clk); adr0 = 16'h0002;
    chk("t3/busy0", {15'd0, busy0}, 16'd0);
    chk("t3/wr0", {15'd0, wr0}, 16'd1);
    chk("t3/rd0", rd0, 16'h1111);
    @(negedge clk); adr0 = 16'h0004;
    chk("t3/busy1", {15'd0, busy0}, 16'd0);
    chk("t3/wr1", {15'd0, wr0}, 16'd1);
    chk("t3/rd1", rd0, 16'h2222);
    @(negedge clk); en0 = 1'b0;
    chk("t3/busy2", {15'd0, busy0}, 16'd0);
    chk("t3/wr2", {15'd0, wr0}, 16'd1);
    chk("t3/rd2", rd0, 16'h3333);
    @(negedge clk);
    chk("t3/wr_end", {15'd0, wr0}, 16'd0);
    chk("t3/rd_hold", rd0, 16'h3333);
    // Request during BUSY must be ignored; odd word read aligns down and flags misalign.
    req2(1'b1, 1'b0, 16'h0012, 16'hCAFE, 16'h0012, 1'b0, "t4w");
    @(negedge clk); en = 1'b1; rw = 1'b0; byt = 1'b0; adr = 16'h0013;
    @(negedge clk); adr = 16'h0010;
    chk("t4/busy1", {15'd0, busy}, 16'd1);
    @(negedge clk); en = 1'b0;
    chk("t4/busy2", {15'd0, busy}, 16'd1);
    @(negedge clk);
    chk("t4/wr", {15'd0, wr}, 16'd1);
    chk("t4/rd", rd, 16'hCAFE);
    chk("t4/mis", {15'd0, mis}, 16'd1);
    @(negedge clk);
    chk("t4/no_second", {15'd0, wr | busy}, 16'd0);
    req2(1'b1, 1'b0, 16'h0015, 16'h7777, 16'hCAFE, 1'b1, "t4mw");
    req2(1'b0, 1'b0, 16'h0014, 16'h0000, 16'h7777, 1'b0, "t4mr");
    // Reset during a pending write drops it.
    req2(1'b1, 1'b0, 16'h0020, 16'h5555, 16'h7777, 1'b0, "t5w");
    @(negedge clk); en = 1'b1; rw = 1'b1; byt = 1'b0; adr = 16'h0020; wd = 16'hAAAA;
    @(negedge clk); en = 1'b0;
    chk("t5/busy", {15'd0, busy}, 16'd1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("t5/busy_rst", {15'd0, busy}, 16'd0);
    chk("t5/wr_rst", {15'd0, wr}, 16'd0);
    chk("t5/rd_rst", rd, 16'h0000);
    @(negedge clk);
    chk("t5/idle", {15'd0, busy | wr}, 16'd0);
    req2(1'b0, 1'b0, 16'h0020, 16'h0000, 16'h5555, 1'b0, "t5r");
    @(negedge clk); rst = 1'b1; en = 1'b1; rw = 1'b0; adr = 16'h0020;
    @(negedge clk); rst = 1'b0; en = 1'b0;
    chk("t5/rst_en_busy", {15'd0, busy}, 16'd0);
    chk("t5/rst_en_rd", rd, 16'h0000);
    @(negedge clk);
    chk("t5/rst_en_wr", {15'd0, wr | busy}, 16'd0);
    // Address bits above ADDR_BITS alias onto the same words.
    req2(1'b1, 1'b0, 16'h0800, 16'h1234, 16'h0000, 1'b0, "t6w");
    req2(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 1'b0, "t6r");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
